fetch_unit: RTL and testbench

- Parametrised instruction fetch front end: issues FETCH_WIDTH consecutive word reads per cycle from the instruction cache.
- Collects complete hit bundles into a QUEUE_DEPTH-entry bundle FIFO.
- Presents the oldest bundle to decode with a valid/ready handshake.
- Sits between the instruction cache and the decoder; adds decoupling buffering, jump redirect with flush, clear, and halt.

---
 rtl/fetch_unit_pkg.sv | 19 +
 rtl/fetch_unit_if.sv | 38 +++
 rtl/fetch_unit_fifo.sv | 61 ++++++
 rtl/fetch_unit.sv | 92 +++++++++
 tb/tb_fetch_unit.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_unit_pkg;

    localparam int unsigned XLEN            = 32;
    localparam int unsigned MAX_FETCH_WIDTH = 4;
    localparam logic [XLEN-1:0] NOP_INSTR   = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] address;
        logic [XLEN-1:0] instr;
    } fetch_lane_t;

    // Word address of lane k within a bundle starting at base.
    function automatic logic [XLEN-1:0] lane_addr(input logic [XLEN-1:0] base,
                                                  input int unsigned     lane);
        return base + XLEN'(4 * lane);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Cache request, redirect/control and decode handshake signals of the fetch unit.
interface fetch_if #(
    parameter int unsigned FETCH_WIDTH = 2,
    parameter int unsigned QUEUE_DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1;

    logic [FETCH_WIDTH-1:0][31:0] o_cache_address;
    logic                         o_cache_read;
    logic [FETCH_WIDTH-1:0][31:0] i_cache_instr;
    logic [FETCH_WIDTH-1:0]       i_cache_hit;
    logic [31:0]                  i_jmp_address;
    logic                         i_jmp_write;
    logic                         i_clear;
    logic                         i_halt;
    logic [FETCH_WIDTH-1:0][31:0] o_address;
    logic [FETCH_WIDTH-1:0][31:0] o_instr;
    logic                         o_valid;
    logic                         i_ready;
    logic [CNT_W-1:0]             o_count;

    modport master (
        output o_cache_address, o_cache_read,
        input  i_cache_instr, i_cache_hit,
        input  i_jmp_address, i_jmp_write, i_clear, i_halt,
        output o_address, o_instr, o_valid, o_count,
        input  i_ready
    );

    modport slave (
        input  o_cache_address, o_cache_read,
        output i_cache_instr, i_cache_hit,
        output i_jmp_address, i_jmp_write, i_clear, i_halt,
        input  o_address, o_instr, o_valid, o_count,
        output i_ready
    );

endinterface

// File: rtl/fetch_unit_fifo.sv
// Bundle FIFO: power-of-two depth, flush collapses the queue without touching storage.
module fetch_unit_fifo #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [DATA_WIDTH-1:0]    din,
    output logic [DATA_WIDTH-1:0]    dout,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; the head is masked downstream while empty.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr_q] <= din;
    end

    assign dout  = mem[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, bundle request/accept, jump/clear/halt, decode-side muxing.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned FETCH_WIDTH  = 2,
    parameter int unsigned QUEUE_DEPTH  = 4
) (
    input  logic      i_clock,
    input  logic      i_reset,
    fetch_if.master   bus
);
    localparam int unsigned CNT_W   = $clog2(QUEUE_DEPTH) + 1;
    localparam int unsigned LANE_W  = $bits(fetch_lane_t);
    localparam int unsigned DATA_W  = LANE_W * FETCH_WIDTH;
    localparam int unsigned PC_STEP = 4 * FETCH_WIDTH;

    logic [31:0]                       pc_q, pc_d;
    fetch_lane_t [FETCH_WIDTH-1:0]     push_bundle;
    fetch_lane_t [FETCH_WIDTH-1:0]     head_bundle;
    logic [DATA_W-1:0]                 fifo_dout;
    logic [CNT_W-1:0]                  fifo_count;
    logic                              valid;
    logic                              full;
    logic                              flush;
    logic                              pop;
    logic                              req;
    logic                              push;

    // Jump and clear both flush and suppress any same-cycle queue traffic.
    always_comb begin
        valid = (fifo_count != '0);
        full  = (fifo_count == CNT_W'(QUEUE_DEPTH));
        flush = bus.i_jmp_write | bus.i_clear;
        pop   = valid & bus.i_ready & ~bus.i_halt & ~flush;
        req   = ~bus.i_halt & ~flush & (~full | pop);
        push  = req & (&bus.i_cache_hit);
    end

    always_comb begin
        pc_d = pc_q;
        if (bus.i_jmp_write) begin
            pc_d = bus.i_jmp_address & ~32'h0000_0003;
        end else if (push) begin
            pc_d = pc_q + 32'(PC_STEP);
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) pc_q <= RESET_VECTOR;
        else         pc_q <= pc_d;
    end

    always_comb begin
        push_bundle = '0;
        for (int unsigned k = 0; k < FETCH_WIDTH; k++) begin
            push_bundle[k].address = lane_addr(pc_q, k);
            push_bundle[k].instr   = bus.i_cache_instr[k];
        end
    end

    fetch_unit_fifo #(
        .DATA_WIDTH (DATA_W),
        .DEPTH      (QUEUE_DEPTH)
    ) u_fifo (
        .clk   (i_clock),
        .rst   (i_reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (push_bundle),
        .dout  (fifo_dout),
        .count (fifo_count)
    );

    assign head_bundle = fifo_dout;

    always_comb begin
        bus.o_cache_read    = req;
        bus.o_valid         = valid;
        bus.o_count         = fifo_count;
        bus.o_cache_address = '0;
        bus.o_address       = '0;
        bus.o_instr         = '0;
        for (int unsigned k = 0; k < FETCH_WIDTH; k++) begin
            bus.o_cache_address[k] = lane_addr(pc_q, k);
            bus.o_address[k]       = valid ? head_bundle[k].address : 32'h0;
            bus.o_instr[k]         = valid ? head_bundle[k].instr   : NOP_INSTR;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (FETCH_WIDTH=2, QUEUE_DEPTH=4).
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [31:0] TAG = 32'hCAFE_0000;

    logic       clk;
    logic       rst;
    logic [1:0] hit_mask;
    int         checks;
    int         errors;

    fetch_if #(.FETCH_WIDTH(2), .QUEUE_DEPTH(4)) bus ();

    fetch_unit #(
        .RESET_VECTOR (32'h0000_0000),
        .FETCH_WIDTH  (2),
        .QUEUE_DEPTH  (4)
    ) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cache model: data is a tagged copy of the requested address.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            bus.i_cache_instr[k] = bus.o_cache_address[k] ^ TAG;
        end
        bus.i_cache_hit = hit_mask;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag, input logic [31:0] a0, input logic [31:0] cnt);
        check({tag, "_count"}, 32'(bus.o_count), cnt);
        check({tag, "_valid"}, 32'(bus.o_valid), 32'd1);
        check({tag, "_addr0"}, bus.o_address[0], a0);
        check({tag, "_addr1"}, bus.o_address[1], a0 + 32'd4);
        check({tag, "_instr1"}, bus.o_instr[1], (a0 + 32'd4) ^ TAG);
    endtask

    initial begin
        checks            = 0;
        errors            = 0;
        rst               = 1'b1;
        hit_mask          = 2'b11;
        bus.i_ready       = 1'b0;
        bus.i_jmp_write   = 1'b0;
        bus.i_jmp_address = 32'h0;
        bus.i_clear       = 1'b0;
        bus.i_halt        = 1'b0;
        step();
        step();

        // Reset state
        check("rst_valid", 32'(bus.o_valid), 32'd0);
        check("rst_count", 32'(bus.o_count), 32'd0);
        check("rst_addr0", bus.o_address[0], 32'h0);
        check("rst_instr0", bus.o_instr[0], NOP_INSTR);
        check("rst_instr1", bus.o_instr[1], NOP_INSTR);
        check("rst_caddr1", bus.o_cache_address[1], 32'h4);

        // Fill: four pushes, decoder stalled
        #2 rst = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check_head("fill", 32'h0, 32'd4);
        check("fill_instr0", bus.o_instr[0], 32'h0 ^ TAG);
        check("fill_cread", 32'(bus.o_cache_read), 32'd0);
        check("fill_pc", bus.o_cache_address[0], 32'd32);

        // Miss stall at 0x40
        bus.i_jmp_write   = 1'b1;
        bus.i_jmp_address = 32'h40;
        step();
        bus.i_jmp_write = 1'b0;
        hit_mask        = 2'b01;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("miss_cread", 32'(bus.o_cache_read), 32'd1);
            step();
            check("miss_count", 32'(bus.o_count), 32'd0);
            check("miss_caddr0", bus.o_cache_address[0], 32'h40);
            check("miss_caddr1", bus.o_cache_address[1], 32'h44);
        end
        hit_mask = 2'b11;
        step();
        check_head("hit", 32'h40, 32'd1);

        // Refill to full, then concurrent push/pop
        for (int i = 0; i < 3; i++) step();
        check_head("full", 32'h40, 32'd4);
        bus.i_ready = 1'b1;
        step();
        check_head("pp0", 32'h48, 32'd4);
        step();
        check_head("pp1", 32'h50, 32'd4);
        step();
        check_head("pp2", 32'h58, 32'd4);

        // Pop only, then jump flush with 3 queued
        hit_mask = 2'b00;
        step();
        check_head("pop", 32'h60, 32'd3);
        bus.i_ready       = 1'b0;
        bus.i_jmp_write   = 1'b1;
        bus.i_jmp_address = 32'h1003;
        step();
        check("jmp_count", 32'(bus.o_count), 32'd0);
        check("jmp_valid", 32'(bus.o_valid), 32'd0);
        check("jmp_instr0", bus.o_instr[0], NOP_INSTR);
        check("jmp_addr0", bus.o_address[0], 32'h0);
        check("jmp_caddr0", bus.o_cache_address[0], 32'h1000);
        check("jmp_caddr1", bus.o_cache_address[1], 32'h1004);

        // Halt holds everything
        bus.i_jmp_write = 1'b0;
        hit_mask        = 2'b11;
        step();
        step();
        check_head("prehalt", 32'h1000, 32'd2);
        bus.i_halt  = 1'b1;
        bus.i_ready = 1'b1;
        #1;
        check("halt_cread", 32'(bus.o_cache_read), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check_head("halt", 32'h1000, 32'd2);
            check("halt_pc", bus.o_cache_address[0], 32'h1010);
        end
        bus.i_clear = 1'b1;
        step();
        check("hclr_count", 32'(bus.o_count), 32'd0);
        check("hclr_pc", bus.o_cache_address[0], 32'h1010);
        bus.i_clear = 1'b0;
        bus.i_halt  = 1'b0;

        // PC wrap at top of address space
        bus.i_ready       = 1'b0;
        bus.i_jmp_write   = 1'b1;
        bus.i_jmp_address = 32'hFFFF_FFF8;
        step();
        bus.i_jmp_write = 1'b0;
        check("wrap_caddr1", bus.o_cache_address[1], 32'hFFFF_FFFC);
        step();
        check_head("wrap", 32'hFFFF_FFF8, 32'd1);
        check("wrap_pc", bus.o_cache_address[0], 32'h0);

        // Async reset between edges
        step();
        check("prerst_count", 32'(bus.o_count), 32'd2);
        #3 rst = 1'b1;
        #1;
        check("arst_count", 32'(bus.o_count), 32'd0);
        check("arst_valid", 32'(bus.o_valid), 32'd0);
        check("arst_pc", bus.o_cache_address[0], 32'h0);
        check("arst_instr0", bus.o_instr[0], NOP_INSTR);
        #1 rst = 1'b0;
        step();
        check_head("postrst", 32'h0, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
